// File: rtl/types_pkg.sv
// types_pkg: shared scratchpad constants and the memory responder FSM state type
//   WORD_W       byte-address width
//   BITS_PER_ROW width of one matrix row
//   ROW_S_W      width of a row index inside a 4-row matrix
//   ROW_SHIFT    address bits covered by one row (bytes per row, log2)
package types_pkg;
    localparam int WORD_W       = 32;
    localparam int BITS_PER_ROW = 64;
    localparam int ROW_S_W      = 2;
    localparam int ROW_SHIFT    = $clog2(BITS_PER_ROW / 8);
    typedef enum logic [2:0] {IDLE, LWAIT, LSEND, SWAIT, DRAIN} sp_resp_state_t;
endpackage

// File: rtl/sp_resp_mem.sv
// sp_resp_mem: MEM_ROWS x BITS_PER_ROW backing array for sp_mem_responder
//   clk                          clock
//   init_wen/init_row/init_wdata backdoor write port, wins over a store to the same row
//   st_wen/st_row/st_wdata       store write port
//   rd_row/rdata                 combinational read port
module sp_resp_mem
    import types_pkg::*;
#(
    parameter int MEM_ROWS = 1024,
    localparam int AW = $clog2(MEM_ROWS)
) (
    input  logic                    clk,
    input  logic                    init_wen,
    input  logic [AW-1:0]           init_row,
    input  logic [BITS_PER_ROW-1:0] init_wdata,
    input  logic                    st_wen,
    input  logic [AW-1:0]           st_row,
    input  logic [BITS_PER_ROW-1:0] st_wdata,
    input  logic [AW-1:0]           rd_row,
    output logic [BITS_PER_ROW-1:0] rdata
);
    logic [BITS_PER_ROW-1:0] mem [MEM_ROWS];

    always_ff @(posedge clk) begin
        if (init_wen) mem[init_row] <= init_wdata;
        if (st_wen && !(init_wen && init_row == st_row)) mem[st_row] <= st_wdata;
    end

    assign rdata = mem[rd_row];
endmodule

// File: rtl/sp_mem_responder.sv
// sp_mem_responder: DRAM-side responder serving 4-row matrix loads and single-row stores
//   CLK, RST                                  clock, synchronous active-high reset
//   sLoad, load_addr                          load request and row-0 byte address
//   load_data, sLoad_hit, sLoad_row           registered load beat outputs
//   sStore, store_addr, store_data            store request
//   sStore_hit                                one-cycle store acknowledge
//   init_wen, init_row, init_wdata            backdoor preload
//   busy                                      FSM not idle
//   err (only with SP_MEM_BOUNDS_EN)          sticky out-of-range address flag
// Define SP_MEM_BOUNDS_EN to flag addresses beyond MEM_ROWS instead of wrapping them.
module sp_mem_responder
    import types_pkg::*;
#(
    parameter int MEM_ROWS = 1024,
    parameter int LAT      = 4
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        sLoad,
    input  logic [WORD_W-1:0]           load_addr,
    output logic [BITS_PER_ROW-1:0]     load_data,
    output logic                        sLoad_hit,
    output logic [ROW_S_W-1:0]          sLoad_row,
    input  logic                        sStore,
    input  logic [WORD_W-1:0]           store_addr,
    input  logic [BITS_PER_ROW-1:0]     store_data,
    output logic                        sStore_hit,
    input  logic                        init_wen,
    input  logic [$clog2(MEM_ROWS)-1:0] init_row,
    input  logic [BITS_PER_ROW-1:0]     init_wdata,
    output logic                        busy
`ifdef SP_MEM_BOUNDS_EN
    ,
    output logic                        err
`endif
);
    localparam int AW = $clog2(MEM_ROWS);
    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

    sp_resp_state_t          state, state_n;
    logic [CW-1:0]           cnt, cnt_n;
    logic [ROW_S_W-1:0]      beat, beat_n;
    logic [AW-1:0]           base, base_n, srow, srow_n, rd_row;
    logic [BITS_PER_ROW-1:0] sdata, sdata_n, rdata, data_n;
    logic                    is_load, is_load_n, oob, oob_n, st_we, hit_n, wait_done;
    logic [AW-1:0]           ld_row, st_row;
    logic                    ld_oob, st_oob;

    assign ld_row    = AW'(load_addr >> ROW_SHIFT);
    assign st_row    = AW'(store_addr >> ROW_SHIFT);
    assign wait_done = int'(cnt) == LAT - 1;
`ifdef SP_MEM_BOUNDS_EN
    assign ld_oob = |(load_addr >> (ROW_SHIFT + AW));
    assign st_oob = |(store_addr >> (ROW_SHIFT + AW));
`else
    assign ld_oob = 1'b0;
    assign st_oob = 1'b0;
`endif

    sp_resp_mem #(.MEM_ROWS(MEM_ROWS)) u_mem (
        .clk        (CLK),
        .init_wen   (init_wen),
        .init_row   (init_row),
        .init_wdata (init_wdata),
        .st_wen     (st_we && !oob_n && !RST),
        .st_row     (srow_n),
        .st_wdata   (sdata_n),
        .rd_row     (rd_row),
        .rdata      (rdata)
    );

    // Outputs are registered from the next-state values, so a beat is visible
    // exactly in the cycles the FSM spends in LSEND.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            cnt        <= '0;
            beat       <= '0;
            base       <= '0;
            srow       <= '0;
            sdata      <= '0;
            is_load    <= 1'b0;
            oob        <= 1'b0;
            load_data  <= '0;
            sLoad_hit  <= 1'b0;
            sLoad_row  <= '0;
            sStore_hit <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            beat       <= beat_n;
            base       <= base_n;
            srow       <= srow_n;
            sdata      <= sdata_n;
            is_load    <= is_load_n;
            oob        <= oob_n;
            load_data  <= data_n;
            sLoad_hit  <= hit_n;
            sLoad_row  <= hit_n ? beat_n : '0;
            sStore_hit <= st_we;
            busy       <= state_n != IDLE;
        end
    end

`ifdef SP_MEM_BOUNDS_EN
    always_ff @(posedge CLK) begin
        if (RST) err <= 1'b0;
        else if (state == IDLE && state_n != IDLE && oob_n) err <= 1'b1;
    end
`endif

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        beat_n    = beat;
        base_n    = base;
        srow_n    = srow;
        sdata_n   = sdata;
        is_load_n = is_load;
        oob_n     = oob;
        st_we     = 1'b0;
        case (state)
            IDLE: begin
                if (sLoad) begin
                    base_n    = ld_row;
                    oob_n     = ld_oob;
                    is_load_n = 1'b1;
                    cnt_n     = '0;
                    beat_n    = '0;
                    state_n   = (LAT == 0) ? LSEND : LWAIT;
                end else if (sStore) begin
                    srow_n    = st_row;
                    sdata_n   = store_data;
                    oob_n     = st_oob;
                    is_load_n = 1'b0;
                    cnt_n     = '0;
                    st_we     = LAT == 0;
                    state_n   = (LAT == 0) ? DRAIN : SWAIT;
                end
            end
            LWAIT: begin
                if (!sLoad) state_n = IDLE;
                else if (wait_done) state_n = LSEND;
                else cnt_n = cnt + 1'b1;
            end
            LSEND: begin
                if (!sLoad) state_n = IDLE;
                else if (&beat) state_n = DRAIN;
                else beat_n = beat + 1'b1;
            end
            SWAIT: begin
                if (!sStore) state_n = IDLE;
                else if (wait_done) begin
                    st_we   = 1'b1;
                    state_n = DRAIN;
                end else cnt_n = cnt + 1'b1;
            end
            DRAIN: begin
                // Hold here until the served request is released, so it is not served twice.
                if (!(is_load ? sLoad : sStore)) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        hit_n  = state_n == LSEND;
        rd_row = base_n + AW'(beat_n);
        data_n = (hit_n && !oob_n) ? rdata : '0;
    end
endmodule

// File: tb/tb_sp_mem_responder.sv
// tb_sp_mem_responder: randomized and directed bench for sp_mem_responder against a timeline model
module tb_sp_mem_responder;
    localparam int L  = 4;
    localparam int MR = 1024;
    localparam int NC = 8192;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sLoad = 1'b0, sStore = 1'b0, init_wen = 1'b0;
    logic [31:0] load_addr = '0, store_addr = '0;
    logic [63:0] store_data = '0, init_wdata = '0, load_data;
    logic [9:0]  init_row = '0;
    logic        sLoad_hit, sStore_hit, busy;
    logic [1:0]  sLoad_row;
`ifdef SP_MEM_BOUNDS_EN
    logic        err;
`endif

    sp_mem_responder #(.MEM_ROWS(MR), .LAT(L)) dut (
        .CLK        (clk),
        .RST        (rst),
        .sLoad      (sLoad),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .sLoad_hit  (sLoad_hit),
        .sLoad_row  (sLoad_row),
        .sStore     (sStore),
        .store_addr (store_addr),
        .store_data (store_data),
        .sStore_hit (sStore_hit),
        .init_wen   (init_wen),
        .init_row   (init_row),
        .init_wdata (init_wdata),
        .busy       (busy)
`ifdef SP_MEM_BOUNDS_EN
        ,
        .err        (err)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, errors = 0;
    bit chk_on = 1'b0;

    // Expected outputs per cycle, filled in by the request drivers from the timing rules.
    bit          e_hit [NC];
    bit          e_shit [NC];
    bit          e_busy [NC];
    bit          e_err [NC];
    logic [1:0]  e_row [NC];
    logic [63:0] e_data [NC];
    logic [63:0] mem_m [MR];

    function automatic void chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h, want %h", n, cyc, a, e);
        end
    endfunction

    function automatic bit is_oob(input logic [31:0] a);
`ifdef SP_MEM_BOUNDS_EN
        return (a >> 13) != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int row_of(input logic [31:0] a);
        return int'((a >> 3) % MR);
    endfunction

    // Load accepted in cycle t, request low from cycle d (or reset in cycle d).
    function automatic void sched_load(input int t, input int d, input logic [31:0] a);
        int b = row_of(a);
        for (int r = 0; r < 4; r++) begin
            int c = t + 1 + L + r;
            if (c <= d && c < NC) begin
                e_hit[c]  = 1'b1;
                e_row[c]  = 2'(r);
                e_data[c] = is_oob(a) ? 64'd0 : mem_m[(b + r) % MR];
            end
        end
        for (int c = t + 1; c <= d && c < NC; c++) e_busy[c] = 1'b1;
        if (is_oob(a)) for (int c = t + 1; c < NC; c++) e_err[c] = 1'b1;
    endfunction

    function automatic void sched_store(input int t, input int d, input logic [31:0] a, input logic [63:0] v);
        int c = t + 1 + L;
        if (c <= d && c < NC) begin
            e_shit[c] = 1'b1;
            if (!is_oob(a)) mem_m[row_of(a)] = v;
        end
        for (int k = t + 1; k <= d && k < NC; k++) e_busy[k] = 1'b1;
        if (is_oob(a)) for (int k = t + 1; k < NC; k++) e_err[k] = 1'b1;
    endfunction

    always @(negedge clk) begin
        if (chk_on && cyc < NC) begin
            chk("sLoad_hit", 64'(sLoad_hit), 64'(e_hit[cyc]));
            if (e_hit[cyc]) begin
                chk("sLoad_row", 64'(sLoad_row), 64'(e_row[cyc]));
                chk("load_data", load_data, e_data[cyc]);
            end
            chk("sStore_hit", 64'(sStore_hit), 64'(e_shit[cyc]));
            chk("busy", 64'(busy), 64'(e_busy[cyc]));
`ifdef SP_MEM_BOUNDS_EN
            chk("err", 64'(err), 64'(e_err[cyc]));
`endif
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic neg_at(input int c);
        do @(negedge clk); while (cyc < c);
    endtask

    task automatic do_load(input logic [31:0] a, input int hold);
        int t = cyc;
        sLoad = 1'b1;
        load_addr = a;
        sched_load(t, t + hold, a);
        step(hold);
        sLoad = 1'b0;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [63:0] v, input int hold);
        int t = cyc;
        sStore = 1'b1;
        store_addr = a;
        store_data = v;
        sched_store(t, t + hold, a, v);
        step(hold);
        sStore = 1'b0;
    endtask

    task automatic do_init(input int r, input logic [63:0] v);
        init_wen = 1'b1;
        init_row = 10'(r);
        init_wdata = v;
        mem_m[r] = v;
        step(1);
        init_wen = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a = {19'd0, 10'($urandom_range(0, MR - 1)), 3'($urandom_range(0, 7))};
`ifndef SP_MEM_BOUNDS_EN
        a[31:13] = 19'($urandom_range(0, 7));
`endif
        return a;
    endfunction

    initial begin
        int t;
        step(1);
        chk_on = 1'b1;
        step(2);
        rst = 1'b0;
        neg_at(cyc);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_hit", 64'(sLoad_hit), 64'd0);
        step(1);
        for (int i = 0; i < MR; i++) begin
            init_wen = 1'b1;
            init_row = 10'(i);
            init_wdata = {$urandom, $urandom};
            mem_m[i] = init_wdata;
            step(1);
        end
        init_wen = 1'b0;
        for (int r = 0; r < 4; r++) do_init(16 + r, 64'h1111_1111_1111_1111 * 64'(r + 1));
        step(2);

        // Matrix load from 0x80: beats at t+5..t+8 with the preloaded row values.
        t = cyc;
        fork
            do_load(32'h80, L + 5);
            begin
                neg_at(t + L);
                chk("lit_pre_hit", 64'(sLoad_hit), 64'd0);
                for (int r = 0; r < 4; r++) begin
                    neg_at(t + L + 1 + r);
                    chk("lit_hit", 64'(sLoad_hit), 64'd1);
                    chk("lit_row", 64'(sLoad_row), 64'(r));
                    chk("lit_data", load_data, 64'h1111_1111_1111_1111 * 64'(r + 1));
                    chk("lit_busy", 64'(busy), 64'd1);
                end
            end
        join
        step(2);

        // Store to 0x100: acknowledged exactly at t+5, then read back on beat 0.
        t = cyc;
        fork
            do_store(32'h100, 64'hDEAD_BEEF_CAFE_F00D, L + 1);
            begin
                neg_at(t + L);
                chk("lit_shit_early", 64'(sStore_hit), 64'd0);
                neg_at(t + L + 1);
                chk("lit_shit", 64'(sStore_hit), 64'd1);
            end
        join
        step(1);
        neg_at(cyc);
        chk("lit_shit_after", 64'(sStore_hit), 64'd0);
        step(1);
        t = cyc;
        fork
            do_load(32'h100, L + 5);
            begin
                neg_at(t + L + 1);
                chk("lit_store_rb", load_data, 64'hDEAD_BEEF_CAFE_F00D);
            end
        join
        step(2);

        // Load and store together: load first, store after the load drains.
        t = cyc;
        sLoad = 1'b1;
        sStore = 1'b1;
        load_addr = 32'h200;
        store_addr = 32'h208;
        store_data = 64'h5555_AAAA_5555_AAAA;
        sched_load(t, t + L + 5, 32'h200);
        sched_store(t + L + 6, t + 2 * L + 7, 32'h208, 64'h5555_AAAA_5555_AAAA);
        step(L + 5);
        sLoad = 1'b0;
        step(L + 2);
        sStore = 1'b0;
        neg_at(cyc);
        chk("lit_both_shit", 64'(sStore_hit), 64'd1);
        step(2);

        // Held request gets no second burst; re-raise gets exactly one.
        do_load(32'h80, L + 8);
        step(1);
        do_load(32'h80, L + 5);
        step(2);

        // Abort after beat 1, and an aborted store leaves the row untouched.
        do_load(32'h80, L + 2);
        step(1);
        do_init(50, 64'hA5A5_A5A5_A5A5_A5A5);
        do_store(32'h190, 64'h0, 2);
        step(1);
        t = cyc;
        fork
            do_load(32'h190, L + 5);
            begin
                neg_at(t + L + 1);
                chk("lit_abort_keep", load_data, 64'hA5A5_A5A5_A5A5_A5A5);
            end
        join
        step(2);

        // Init write to the same row in the store commit cycle wins.
        t = cyc;
        sStore = 1'b1;
        store_addr = 32'h140;
        store_data = 64'hFFFF_0000_FFFF_0000;
        sched_store(t, t + L + 1, 32'h140, 64'hFFFF_0000_FFFF_0000);
        step(L);
        do_init(40, 64'h0123_4567_89AB_CDEF);
        sStore = 1'b0;
        step(1);
        t = cyc;
        fork
            do_load(32'h140, L + 5);
            begin
                neg_at(t + L + 1);
                chk("lit_init_wins", load_data, 64'h0123_4567_89AB_CDEF);
            end
        join
        step(2);

        // Wrap across the top of the array.
        do_load(32'h1FF0, L + 5);
        step(2);

        // Reset during LSEND clears every output on the next cycle.
        t = cyc;
        sLoad = 1'b1;
        load_addr = 32'h80;
        sched_load(t, t + L + 2, 32'h80);
        step(L + 2);
        rst = 1'b1;
        sLoad = 1'b0;
        for (int c = t + L + 3; c < NC; c++) e_err[c] = 1'b0;
        step(1);
        rst = 1'b0;
        neg_at(cyc);
        chk("lit_rst_hit", 64'(sLoad_hit), 64'd0);
        chk("lit_rst_row", 64'(sLoad_row), 64'd0);
        chk("lit_rst_data", load_data, 64'd0);
        chk("lit_rst_busy", 64'(busy), 64'd0);
        step(2);

`ifdef SP_MEM_BOUNDS_EN
        t = cyc;
        fork
            do_load(32'h10000, L + 5);
            begin
                neg_at(t + L + 1);
                chk("lit_oob_data", load_data, 64'd0);
                chk("lit_oob_err", 64'(err), 64'd1);
            end
        join
        step(2);
        rst = 1'b1;
        for (int c = cyc + 1; c < NC; c++) e_err[c] = 1'b0;
        step(1);
        rst = 1'b0;
        neg_at(cyc);
        chk("lit_err_clr", 64'(err), 64'd0);
        step(1);
`endif

        for (int i = 0; i < 80; i++) begin
            int k = $urandom_range(0, 9);
            logic [31:0] a = rand_addr();
            if (k < 5) do_load(a, $urandom_range(1, L + 8));
            else if (k < 9) do_store(a, {$urandom, $urandom}, $urandom_range(1, L + 4));
            else do_init($urandom_range(0, MR - 1), {$urandom, $urandom});
            step($urandom_range(1, 3));
        end
        step(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
